// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: EX operand forwarding, load-use interlock, branch flush and MDU register scoreboard
// for the 5-stage RV32 pipeline. Define HAZ_PERF_CNT_EN to add the perf_stall_cnt / perf_flush_cnt counters.
module hazard_ctrl_sb #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reg_write_m,
    input  logic                   reg_write_w,
    input  logic                   result_src_m0,
    input  logic                   result_src_e0,
    input  logic [REG_AW-1:0]      rd_m,
    input  logic [REG_AW-1:0]      rd_w,
    input  logic [REG_AW-1:0]      rd_e,
    input  logic [REG_AW-1:0]      rs1_e,
    input  logic [REG_AW-1:0]      rs2_e,
    input  logic [REG_AW-1:0]      rs1_d,
    input  logic [REG_AW-1:0]      rs2_d,
    input  logic [REG_AW-1:0]      rd_d,
    input  logic                   reg_write_d,
    input  logic                   mdu_op_d,
    input  logic                   mdu_start_e,
    input  logic                   mdu_done,
    input  logic [REG_AW-1:0]      mdu_rd,
    input  logic                   pc_src_e,
    output logic                   stall_f,
    output logic                   stall_d,
    output logic                   flush_d,
    output logic                   flush_e,
    output logic [1:0]             forward_a_e,
    output logic [1:0]             forward_b_e,
    output logic                   mdu_busy,
    output logic [(2**REG_AW)-1:0] sb_pending
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_flush_cnt
`endif
);

    localparam int                NREGS     = 2**REG_AW;
    localparam logic [1:0]        FWD_RF    = 2'b00;
    localparam logic [1:0]        FWD_MEM   = 2'b10;
    localparam logic [1:0]        FWD_WB    = 2'b01;
    localparam logic [1:0]        LD_RELOAD = 2'(LOAD_LAT - 1);
    localparam logic [REG_AW-1:0] REG_X0    = '0;
    localparam logic [NREGS-1:0]  X0_MASK   = {{(NREGS-1){1'b1}}, 1'b0};

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              wr_m,
        input logic [REG_AW-1:0] dst_m,
        input logic              mem_ok,
        input logic              wr_w,
        input logic [REG_AW-1:0] dst_w
    );
        logic [1:0] sel;
        if (wr_m && mem_ok && (dst_m != REG_X0) && (dst_m == src)) begin
            sel = FWD_MEM;
        end else if (wr_w && (dst_w != REG_X0) && (dst_w == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    logic [NREGS-1:0]  pending_q, pending_d;
    logic              mdu_busy_q, mdu_busy_d;
    logic [1:0]        ld_cnt_q, ld_cnt_d;
    logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
    logic              init_q;
    logic              out_blk_s;
    logic              mem_fwd_ok_s;
    logic              hit_ld_s, hit_cnt_s, hit_sb_s, stall_s;
    logic              sb_set_s;
    logic [NREGS-1:0]  set_mask_s, clr_mask_s;
    logic [1:0]        fwd_a_s, fwd_b_s;

    // Outputs are held quiet during reset and for the first cycle after release.
    assign out_blk_s = rst | init_q;

    // Operand forwarding; with a 2-cycle load, MEM holds no load data yet.
    always_comb begin
        mem_fwd_ok_s = (LOAD_LAT == 2) ? ~result_src_m0 : 1'b1;
        fwd_a_s      = fwd_sel(rs1_e, reg_write_m, rd_m, mem_fwd_ok_s, reg_write_w, rd_w);
        fwd_b_s      = fwd_sel(rs2_e, reg_write_m, rd_m, mem_fwd_ok_s, reg_write_w, rd_w);
    end

    // Hazard detection: new load-use, load still in flight, scoreboard and structural MDU hazard.
    always_comb begin
        hit_ld_s  = result_src_e0 && (rd_e != REG_X0) && ((rs1_d == rd_e) || (rs2_d == rd_e));
        hit_cnt_s = (ld_cnt_q != 2'd0) && (ld_rd_q != REG_X0) &&
                    ((rs1_d == ld_rd_q) || (rs2_d == ld_rd_q));
        hit_sb_s  = pending_q[rs1_d] | pending_q[rs2_d] | (reg_write_d & pending_q[rd_d]) |
                    (mdu_op_d & (mdu_busy_q | mdu_start_e));
        stall_s   = hit_ld_s | hit_cnt_s | hit_sb_s;
    end

    // Pipeline control outputs; a taken branch overrides every stall.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        if (out_blk_s) begin
            stall_f     = 1'b0;
            stall_d     = 1'b0;
            flush_d     = 1'b0;
            flush_e     = 1'b0;
            forward_a_e = FWD_RF;
            forward_b_e = FWD_RF;
        end else begin
            stall_f     = stall_s & ~pc_src_e;
            stall_d     = stall_s & ~pc_src_e;
            flush_d     = pc_src_e;
            flush_e     = pc_src_e | stall_s;
            forward_a_e = fwd_a_s;
            forward_b_e = fwd_b_s;
        end
    end

    // Load latency counter; the branch kills the younger consumer so the count is dropped.
    always_comb begin
        ld_cnt_d = ld_cnt_q;
        ld_rd_d  = ld_rd_q;
        if (pc_src_e) begin
            ld_cnt_d = 2'd0;
        end else if (hit_ld_s) begin
            ld_cnt_d = LD_RELOAD;
            ld_rd_d  = rd_e;
        end else if (ld_cnt_q != 2'd0) begin
            ld_cnt_d = ld_cnt_q - 2'd1;
        end else begin
            ld_cnt_d = ld_cnt_q;
        end
    end

    // Scoreboard next state: a set beats a clear of the same register in the same cycle.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        sb_set_s   = mdu_start_e && (rd_e != REG_X0);
        if (mdu_done) begin
            clr_mask_s[mdu_rd] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
        if (sb_set_s) begin
            set_mask_s[rd_e] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        pending_d = ((pending_q & ~clr_mask_s) | set_mask_s) & X0_MASK;
        if (sb_set_s) begin
            mdu_busy_d = 1'b1;
        end else if (mdu_done) begin
            mdu_busy_d = 1'b0;
        end else begin
            mdu_busy_d = mdu_busy_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            mdu_busy_q <= 1'b0;
            ld_cnt_q   <= 2'd0;
            ld_rd_q    <= '0;
            init_q     <= 1'b1;
        end else begin
            pending_q  <= pending_d;
            mdu_busy_q <= mdu_busy_d;
            ld_cnt_q   <= ld_cnt_d;
            ld_rd_q    <= ld_rd_d;
            init_q     <= 1'b0;
        end
    end

    assign sb_pending = pending_q;
    assign mdu_busy   = mdu_busy_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Event counters, free-running and wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (stall_d) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else begin
                perf_stall_q <= perf_stall_q;
            end
            if (flush_d) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end else begin
                perf_flush_q <= perf_flush_q;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Bench for hazard_ctrl_sb: LOAD_LAT=1 and LOAD_LAT=2 instances share stimulus; forwarding table,
// hand-written multi-cycle sequences and randomized traffic checked against a behavioural model.
module tb_hazard_ctrl_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       reg_write_m, reg_write_w, result_src_m0, result_src_e0;
    logic [4:0] rd_m, rd_w, rd_e, rs1_e, rs2_e, rs1_d, rs2_d, rd_d, mdu_rd;
    logic       reg_write_d, mdu_op_d, mdu_start_e, mdu_done, pc_src_e;

    logic        sf1, sd1, fd1, fe1, busy1, sf2, sd2, fd2, fe2, busy2;
    logic [1:0]  fa1, fb1, fa2, fb2;
    logic [31:0] pend1, pend2;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] ps1, pf1, ps2, pf2;
`endif

    hazard_ctrl_sb #(.REG_AW(5), .LOAD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_m0(result_src_m0), .result_src_e0(result_src_e0), .rd_m(rd_m), .rd_w(rd_w),
        .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .mdu_op_d(mdu_op_d), .mdu_start_e(mdu_start_e),
        .mdu_done(mdu_done), .mdu_rd(mdu_rd), .pc_src_e(pc_src_e), .stall_f(sf1), .stall_d(sd1),
        .flush_d(fd1), .flush_e(fe1), .forward_a_e(fa1), .forward_b_e(fb1), .mdu_busy(busy1),
        .sb_pending(pend1)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1)
`endif
    );

    hazard_ctrl_sb #(.REG_AW(5), .LOAD_LAT(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_m0(result_src_m0), .result_src_e0(result_src_e0), .rd_m(rd_m), .rd_w(rd_w),
        .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .mdu_op_d(mdu_op_d), .mdu_start_e(mdu_start_e),
        .mdu_done(mdu_done), .mdu_rd(mdu_rd), .pc_src_e(pc_src_e), .stall_f(sf2), .stall_d(sd2),
        .flush_d(fd2), .flush_e(fe2), .forward_a_e(fa2), .forward_b_e(fb2), .mdu_busy(busy2),
        .sb_pending(pend2)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(ps2), .perf_flush_cnt(pf2)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: a set of pending registers, a busy flag, and per-latency load bubbles left.
    logic [31:0] m_pend;
    bit          m_busy;
    bit          m_init;
    int          m_ldrem [2];
    logic [4:0]  m_ldreg [2];
    logic [31:0] m_pstall [2];
    logic [31:0] m_pflush;

    typedef struct {
        logic       wm, ww, ldm;
        logic [4:0] rdm, rdw, rs1e, rs2e;
        logic [1:0] fa1, fb1, fa2, fb2;
    } fwd_vec_t;
    fwd_vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act_v, exp_v, $time);
        end
    endtask

    task automatic chk_ctl(input string n, input int k, input bit sf, input bit sd, input bit fd, input bit fe);
        chk({n, " stall_f"}, 64'(k != 0 ? sf2 : sf1), 64'(sf));
        chk({n, " stall_d"}, 64'(k != 0 ? sd2 : sd1), 64'(sd));
        chk({n, " flush_d"}, 64'(k != 0 ? fd2 : fd1), 64'(fd));
        chk({n, " flush_e"}, 64'(k != 0 ? fe2 : fe1), 64'(fe));
    endtask

    task automatic idle;
        reg_write_m = 1'b0; reg_write_w = 1'b0; result_src_m0 = 1'b0; result_src_e0 = 1'b0;
        rd_m = 5'd0; rd_w = 5'd0; rd_e = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rs1_d = 5'd0; rs2_d = 5'd0; rd_d = 5'd0; mdu_rd = 5'd0;
        reg_write_d = 1'b0; mdu_op_d = 1'b0; mdu_start_e = 1'b0; mdu_done = 1'b0; pc_src_e = 1'b0;
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] x, input int lat);
        if (reg_write_m && rd_m == x && rd_m != 5'd0 && !(lat == 2 && result_src_m0)) return 2'b10;
        if (reg_write_w && rd_w == x && rd_w != 5'd0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_raw_stall(input int k);
        bit ld, cnt, sb;
        ld  = result_src_e0 && rd_e != 5'd0 && (rs1_d == rd_e || rs2_d == rd_e);
        cnt = m_ldrem[k] > 0 && m_ldreg[k] != 5'd0 && (rs1_d == m_ldreg[k] || rs2_d == m_ldreg[k]);
        sb  = m_pend[rs1_d] || m_pend[rs2_d] || (reg_write_d && m_pend[rd_d]) ||
              (mdu_op_d && (m_busy || mdu_start_e));
        return ld || cnt || sb;
    endfunction

    task automatic model_clear;
        m_pend = 32'd0; m_busy = 1'b0; m_init = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_ldrem[k] = 0; m_ldreg[k] = 5'd0; m_pstall[k] = 32'd0;
        end
        m_pflush = 32'd0;
    endtask

    task automatic check_model;
        for (int k = 0; k < 2; k++) begin
            bit blk, raw;
            string p;
            p   = (k != 0) ? "rnd L2" : "rnd L1";
            blk = rst || m_init;
            raw = m_raw_stall(k);
            chk_ctl(p, k, !blk && !pc_src_e && raw, !blk && !pc_src_e && raw,
                    !blk && pc_src_e, !blk && (pc_src_e || raw));
            chk({p, " fwd_a"}, 64'(k != 0 ? fa2 : fa1), 64'(blk ? 2'b00 : m_fwd(rs1_e, k + 1)));
            chk({p, " fwd_b"}, 64'(k != 0 ? fb2 : fb1), 64'(blk ? 2'b00 : m_fwd(rs2_e, k + 1)));
            chk({p, " mdu_busy"}, 64'(k != 0 ? busy2 : busy1), 64'(m_busy));
            chk({p, " sb_pending"}, 64'(k != 0 ? pend2 : pend1), 64'(m_pend));
`ifdef HAZ_PERF_CNT_EN
            chk({p, " perf_stall"}, 64'(k != 0 ? ps2 : ps1), 64'(m_pstall[k]));
            chk({p, " perf_flush"}, 64'(k != 0 ? pf2 : pf1), 64'(m_pflush));
`endif
        end
    endtask

    // Advance one clock edge and move the model forward with the inputs that were present at that edge.
    task automatic tick;
        bit st [2];
        bit hit;
        for (int k = 0; k < 2; k++) st[k] = !(rst || m_init) && !pc_src_e && m_raw_stall(k);
        @(posedge clk);
        if (!rst) begin
            if (!m_init) begin
                for (int k = 0; k < 2; k++) if (st[k]) m_pstall[k] = m_pstall[k] + 32'd1;
                if (pc_src_e) m_pflush = m_pflush + 32'd1;
            end
            hit = result_src_e0 && rd_e != 5'd0 && (rs1_d == rd_e || rs2_d == rd_e);
            for (int k = 0; k < 2; k++) begin
                if (pc_src_e) m_ldrem[k] = 0;
                else if (hit) begin m_ldrem[k] = k; m_ldreg[k] = rd_e; end
                else if (m_ldrem[k] > 0) m_ldrem[k] = m_ldrem[k] - 1;
            end
            if (mdu_done) begin m_pend[mdu_rd] = 1'b0; m_busy = 1'b0; end
            if (mdu_start_e && rd_e != 5'd0) begin m_pend[rd_e] = 1'b1; m_busy = 1'b1; end
            m_init = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        model_clear();
        #1;
        check_model();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_model();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        tbl[0] = '{1'b1, 1'b1, 1'b0, 5'd7,  5'd7,  5'd3,  5'd7,  2'b00, 2'b10, 2'b00, 2'b10};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd7,  5'd3,  5'd7,  2'b00, 2'b01, 2'b00, 2'b01};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 5'd7,  5'd7,  5'd3,  5'd0,  2'b00, 2'b00, 2'b00, 2'b00};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 5'd7,  5'd7,  5'd3,  5'd7,  2'b00, 2'b10, 2'b00, 2'b01};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 5'd7,  5'd7,  5'd3,  5'd7,  2'b00, 2'b10, 2'b00, 2'b00};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 5'd4,  5'd4,  5'd4,  5'd4,  2'b01, 2'b01, 2'b01, 2'b01};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 5'd12, 5'd13, 5'd12, 5'd13, 2'b10, 2'b01, 2'b10, 2'b01};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  2'b00, 2'b00, 2'b00, 2'b00};
        @(negedge clk);
        do_reset();

        // Forwarding priority / x0 / load suppression table.
        for (int i = 0; i < 8; i++) begin
            idle();
            reg_write_m = tbl[i].wm; reg_write_w = tbl[i].ww; result_src_m0 = tbl[i].ldm;
            rd_m = tbl[i].rdm; rd_w = tbl[i].rdw; rs1_e = tbl[i].rs1e; rs2_e = tbl[i].rs2e;
            #1;
            chk($sformatf("tbl%0d fa L1", i), 64'(fa1), 64'(tbl[i].fa1));
            chk($sformatf("tbl%0d fb L1", i), 64'(fb1), 64'(tbl[i].fb1));
            chk($sformatf("tbl%0d fa L2", i), 64'(fa2), 64'(tbl[i].fa2));
            chk($sformatf("tbl%0d fb L2", i), 64'(fb2), 64'(tbl[i].fb2));
            tick();
        end

        // Load-use: lw x5 in EX, consumer reads x5 in ID.
        idle(); result_src_e0 = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; reg_write_d = 1'b1; rd_d = 5'd6;
        #1; chk_ctl("ld c0 L1", 0, 1, 1, 0, 1); chk_ctl("ld c0 L2", 1, 1, 1, 0, 1);
        tick();
        idle(); reg_write_m = 1'b1; rd_m = 5'd5; result_src_m0 = 1'b1; rs1_e = 5'd5;
        rs1_d = 5'd5; reg_write_d = 1'b1; rd_d = 5'd6;
        #1; chk_ctl("ld c1 L1", 0, 0, 0, 0, 0); chk_ctl("ld c1 L2", 1, 1, 1, 0, 1);
        chk("ld c1 fa L1", 64'(fa1), 64'(2'b10)); chk("ld c1 fa L2", 64'(fa2), 64'(2'b00));
        tick();
        idle(); reg_write_w = 1'b1; rd_w = 5'd5; rs1_e = 5'd5; rs1_d = 5'd5;
        #1; chk_ctl("ld c2 L1", 0, 0, 0, 0, 0); chk_ctl("ld c2 L2", 1, 0, 0, 0, 0);
        chk("ld c2 fa L1", 64'(fa1), 64'(2'b01)); chk("ld c2 fa L2", 64'(fa2), 64'(2'b01));
        tick();

        // MDU scoreboard: x9 outstanding for four cycles.
        do_reset();
        idle(); mdu_start_e = 1'b1; rd_e = 5'd9;
        #1; chk_ctl("mdu start", 0, 0, 0, 0, 0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            idle(); rs1_d = 5'd9;
            if (c == 4) begin mdu_done = 1'b1; mdu_rd = 5'd9; end
            #1;
            chk_ctl($sformatf("mdu c%0d", c), 1, 1, 1, 0, 1);
            chk($sformatf("mdu c%0d pend9", c), 64'(pend1[9]), 64'd1);
            chk($sformatf("mdu c%0d busy", c), 64'(busy2), 64'd1);
            tick();
        end
        idle(); rs1_d = 5'd9;
        #1; chk_ctl("mdu after", 0, 0, 0, 0, 0);
        chk("mdu after pend", 64'(pend1), 64'd0); chk("mdu after busy", 64'(busy1), 64'd0);
        tick();
        idle(); mdu_op_d = 1'b1; mdu_start_e = 1'b1; rd_e = 5'd3;
        #1; chk_ctl("mdu struct start", 0, 1, 1, 0, 1);
        tick();
        idle(); mdu_op_d = 1'b1;
        #1; chk_ctl("mdu struct busy", 1, 1, 1, 0, 1);
        tick();
        idle(); mdu_done = 1'b1; mdu_rd = 5'd3; mdu_start_e = 1'b1; rd_e = 5'd3;
        #1; chk_ctl("mdu setclr", 0, 0, 0, 0, 0);
        tick();
        idle(); reg_write_d = 1'b1; rd_d = 5'd3;
        #1; chk_ctl("mdu waw", 0, 1, 1, 0, 1);
        chk("mdu set wins pend", 64'(pend2), 64'h8); chk("mdu set wins busy", 64'(busy2), 64'd1);
        tick();
        idle(); mdu_done = 1'b1; mdu_rd = 5'd3;
        #1; tick();
        idle(); mdu_start_e = 1'b1; rd_e = 5'd0;
        #1; tick();
        idle();
        #1; chk("mdu x0 pend", 64'(pend1), 64'd0); chk("mdu x0 busy", 64'(busy1), 64'd0);
        chk_ctl("mdu x0 ctl", 0, 0, 0, 0, 0);

        // Branch during a load-use stall.
        idle(); result_src_e0 = 1'b1; rd_e = 5'd5; rs2_d = 5'd5; pc_src_e = 1'b1;
        #1; chk_ctl("br ld L1", 0, 0, 0, 1, 1); chk_ctl("br ld L2", 1, 0, 0, 1, 1);
        tick();
        idle(); rs2_d = 5'd5;
        #1; chk_ctl("br after L2", 1, 0, 0, 0, 0);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reg_write_m   = 1'($urandom_range(0, 1));
            reg_write_w   = 1'($urandom_range(0, 1));
            result_src_m0 = ($urandom_range(0, 2) == 0);
            result_src_e0 = ($urandom_range(0, 2) == 0);
            rd_m  = 5'($urandom_range(0, 7)); rd_w  = 5'($urandom_range(0, 7));
            rd_e  = 5'($urandom_range(0, 7)); rs1_e = 5'($urandom_range(0, 7));
            rs2_e = 5'($urandom_range(0, 7)); rs1_d = 5'($urandom_range(0, 7));
            rs2_d = 5'($urandom_range(0, 7)); rd_d  = 5'($urandom_range(0, 7));
            mdu_rd = 5'($urandom_range(0, 7));
            reg_write_d = 1'($urandom_range(0, 1));
            mdu_op_d    = ($urandom_range(0, 3) == 0);
            mdu_start_e = ($urandom_range(0, 5) == 0);
            mdu_done    = ($urandom_range(0, 5) == 0);
            pc_src_e    = ($urandom_range(0, 7) == 0);
            #1;
            check_model();
            tick();
        end

        // Reset in the middle of an outstanding MDU op.
        idle(); mdu_start_e = 1'b1; rd_e = 5'd9; pc_src_e = 1'b1;
        #1; tick();
        idle(); mdu_op_d = 1'b1; rs1_d = 5'd9; pc_src_e = 1'b1; reg_write_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
        #1;
        chk("rstmid pre pend9", 64'(pend2[9]), 64'd1); chk("rstmid pre busy", 64'(busy1), 64'd1);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("rstmid pend L1", 64'(pend1), 64'd0); chk("rstmid pend L2", 64'(pend2), 64'd0);
        chk("rstmid busy L1", 64'(busy1), 64'd0); chk("rstmid busy L2", 64'(busy2), 64'd0);
        chk_ctl("rstmid L1", 0, 0, 0, 0, 0); chk_ctl("rstmid L2", 1, 0, 0, 0, 0);
        chk("rstmid fa L1", 64'(fa1), 64'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("rstmid perf_stall", 64'(ps1), 64'd0); chk("rstmid perf_flush", 64'(pf2), 64'd0);
`endif
        tick();
        idle();
        rst = 1'b0;
        #1;
        check_model();
        tick();
        #1;
        check_model();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_sb.md
Name: hazard_ctrl_sb

Overview:
- Parametrised successor to the pipeline hazard unit for the 5-stage RV32 core.
- Keeps the existing jobs:
  - EX-stage operand forwarding from MEM and WB.
  - Load-use stalling.
  - Branch flush.
- Adds:
  - Configurable load latency, held by a stall counter.
  - A per-register scoreboard for the single-outstanding multi-cycle mul/div unit (MDU).
  - WAW protection and x0 filtering on every compare.
- Sits beside the pipeline registers. Drives their stall/flush inputs and the EX operand muxes.

Parameters:
- REG_AW, 5, register address width; NREGS = 2**REG_AW.
- LOAD_LAT, 1, bubbles required after a load before a consumer may issue. Legal values are 1 and 2. With 2, load data is forwardable from WB only.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- reg_write_m  in  1  MEM stage writes the register file
- reg_write_w  in  1  WB stage writes the register file
- result_src_m0  in  1  MEM stage holds a load
- result_src_e0  in  1  EX stage holds a load
- rd_m, rd_w, rd_e  in  REG_AW  destination registers of MEM/WB/EX
- rs1_e, rs2_e  in  REG_AW  EX source registers
- rs1_d, rs2_d, rd_d  in  REG_AW  ID sources and destination
- reg_write_d  in  1  ID instruction writes rd_d
- mdu_op_d  in  1  ID instruction is an MDU op
- mdu_start_e  in  1  MDU op issues from EX this cycle (never asserted for flushed ops)
- mdu_done  in  1  MDU result written this cycle
- mdu_rd  in  REG_AW  destination of the completing MDU op
- pc_src_e  in  1  taken branch/jump redirect from EX
- stall_f, stall_d  out  1  hold IF / ID registers
- flush_d, flush_e  out  1  bubble ID / EX registers
- forward_a_e, forward_b_e  out  2  00 regfile, 10 MEM, 01 WB
- mdu_busy  out  1  MDU op outstanding
- sb_pending  out  NREGS  scoreboard bits

Behaviour:
- Reset state:
  - Scoreboard, mdu_busy, ld_cnt and ld_rd all clear.
  - Every output reads 0 / 00 while rst is high and in the first cycle after release.
  - Reset mid-operation discards all pending state immediately.
- Forwarding (combinational), per operand X in {rs1_e, rs2_e}:
  - MEM match: reg_write_m && rd_m==X && rd_m!=0 && !(LOAD_LAT==2 && result_src_m0) -> 10.
  - Otherwise WB match under the same x0 rule -> 01.
  - Otherwise 00.
  - MEM has priority over WB.
- Load-use:
  - hit_ld = result_src_e0 && rd_e!=0 && (rs1_d==rd_e || rs2_d==rd_e).
  - hit_ld asserts stall_f, stall_d and flush_e.
  - On hit_ld, ld_cnt <= LOAD_LAT-1 and ld_rd <= rd_e.
  - While ld_cnt!=0 and rs1_d or rs2_d equals ld_rd: keep stalling, and decrement ld_cnt each cycle.
  - LOAD_LAT=1 gives exactly one bubble.
  - LOAD_LAT=2 gives two bubbles; the consumer then forwards from WB.
- Scoreboard:
  - On mdu_start_e with rd_e!=0: pending[rd_e] <= 1 and mdu_busy <= 1.
  - On mdu_done: pending[mdu_rd] <= 0 and mdu_busy <= 0.
  - Set and clear of the same register in the same cycle: set wins.
  - Clears take effect the next cycle, so a consumer issues one cycle after mdu_done.
- Scoreboard stall: hit_sb = pending[rs1_d] | pending[rs2_d] | (reg_write_d & pending[rd_d]) | (mdu_op_d & (mdu_busy | mdu_start_e)).
  - hit_sb asserts stall_f, stall_d and flush_e.
- Branch: pc_src_e forces flush_d=1 and flush_e=1, and forces stall_f=stall_d=0. Branch overrides all stalls.
  - It clears ld_cnt.
  - The scoreboard is untouched, because the issued MDU op is older than the branch.
- Bits for x0 are never set. Compares against register 0 never hit.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_stall_cnt and perf_flush_cnt.
  - perf_stall_cnt increments on every cycle stall_d=1.
  - perf_flush_cnt increments on every cycle pc_src_e=1.
  - Both wrap at 2^32, clear on rst, and increment one cycle after the event.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- LOAD_LAT=1: lw x5 in EX, ID uses rs1_d=5 -> stall_f/stall_d/flush_e high for 1 cycle. Next cycle forward_a_e=10 is suppressed only if LOAD_LAT=2; otherwise 10.
- LOAD_LAT=2: same stimulus -> 2 stall cycles, then forward_a_e=01 when the load is in WB.
- Forward priority: rd_m=rd_w=7, rs2_e=7, both writes high -> forward_b_e=10. Repeat with rd_m=0 -> 01. Repeat with rs2_e=0 -> 00.
- MDU: mdu_start_e with rd_e=9, then an ID instruction reading x9. mdu_done arrives 4 cycles later -> stall_d high through the mdu_done cycle, low the next. sb_pending[9] falls one cycle after mdu_done.
- Branch during load-use stall: pc_src_e=1 while hit_ld -> flush_d=flush_e=1, stall_f=stall_d=0, ld_cnt cleared.
- Assert rst mid-MDU with sb_pending[9]=1 and mdu_busy=1 -> all cleared asynchronously, outputs 0. With HAZ_PERF_CNT_EN, counters read 0.
